// File: rtl/mioc_dram_seq_pkg.sv
// Shared definitions for the MIOC DRAM strobe sequencer.
// Holds the FSM state encoding, default timing constants and a one-hot helper.
// No logic or state of its own; imported by the sequencer and its refresh timer.
package mioc_dram_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ROW  = 3'd1,
    ST_COL  = 3'd2,
    ST_HOLD = 3'd3,
    ST_PRE  = 3'd4,
    ST_ZRF  = 3'd5,
    ST_IRF  = 3'd6
  } state_e;

  localparam int DEF_NBANK     = 2;
  localparam int DEF_RA_W      = 7;
  localparam int DEF_T_RAS_MUX = 1;
  localparam int DEF_T_MUX_CAS = 1;
  localparam int DEF_T_PRECHG  = 2;
  localparam int DEF_WAIT_CYC  = 0;
  localparam int DEF_RFSH_INT  = 56;

  // Width of the phase and wait-state counters; all timing parameters fit in it.
  localparam int CNT_W = 8;

  // Bank selects are at most 8 wide; callers zero-extend into this argument.
  function automatic logic is_onehot(input logic [7:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) n += int'(v[i]);
    return (n == 1);
  endfunction

endpackage

// File: rtl/mioc_dram_seq_rfsh_timer.sv
// Internal refresh interval timer, pending flag and refresh row counter.
// Latency: pending sets on the edge the timer reaches RFSH_INT-1; row steps on the done edge.
// Backpressure: pending stays set until take; a new interval may set it again the same edge.
// Ports: B_PHI/RST_N clock and async reset; enable = bus released to DMA master;
//        take = refresh accepted by the sequencer; done = refresh finished;
//        pending = refresh owed; row = row address for the next internal refresh.
module mioc_rfsh_timer
  import mioc_dram_seq_pkg::*;
#(
  parameter int RA_W     = DEF_RA_W,
  parameter int RFSH_INT = DEF_RFSH_INT
) (
  input  logic            B_PHI,
  input  logic            RST_N,
  input  logic            enable,
  input  logic            take,
  input  logic            done,
  output logic            pending,
  output logic [RA_W-1:0] row
);
  localparam int TW = $clog2(RFSH_INT + 1);

  logic [TW-1:0]   tmr_q, tmr_d;
  logic            pend_q, pend_d;
  logic [RA_W-1:0] row_q, row_d;

  always_comb begin
    tmr_d  = tmr_q;
    pend_d = pend_q;
    row_d  = row_q;
    if (take) pend_d = 1'b0;
    // Timer only runs while the Z80 is off the bus; it restarts from zero each release.
    if (!enable) begin
      tmr_d = '0;
    end else if (tmr_q == TW'(RFSH_INT - 1)) begin
      tmr_d  = '0;
      pend_d = 1'b1;
    end else begin
      tmr_d = tmr_q + 1'b1;
    end
    if (done) row_d = row_q + 1'b1;  // wraps naturally at 2^RA_W
  end

  always_ff @(posedge B_PHI or negedge RST_N) begin
    if (!RST_N) begin
      tmr_q  <= '0;
      pend_q <= 1'b0;
      row_q  <= '0;
    end else begin
      tmr_q  <= tmr_d;
      pend_q <= pend_d;
      row_q  <= row_d;
    end
  end

  assign pending = pend_q;
  assign row     = row_q;

endmodule

// File: rtl/mioc_dram_seq.sv
// DRAM RAS/MUX/CAS sequencer with wait states, DMA bus handshake and internal refresh.
// Latency: RAS_N falls 1 cycle after request sample, MUX +T_RAS_MUX, CAS_N +T_MUX_CAS more.
// Backpressure: requests blocked by refresh or precharge hold WAIT_N low until ROW entry.
// Ports: Z80 strobes BMREQ_N/BRFSH_N/BRD_N/N_BWR and BANK_SEL in; RAS_N/MUX/CAS_N to the
//        array; WAIT_N to the bus master; DMA_N/BUSAK_N in, BUSRQ_N/ADDRBUFEN_N out;
//        RFSH_ROW/RFSH_ACT steer the address mux during internal refresh.
module mioc_dram_seq
  import mioc_dram_seq_pkg::*;
#(
  parameter int NBANK     = DEF_NBANK,
  parameter int RA_W      = DEF_RA_W,
  parameter int T_RAS_MUX = DEF_T_RAS_MUX,
  parameter int T_MUX_CAS = DEF_T_MUX_CAS,
  parameter int T_PRECHG  = DEF_T_PRECHG,
  parameter int WAIT_CYC  = DEF_WAIT_CYC,
  parameter int RFSH_INT  = DEF_RFSH_INT
) (
  input  logic             B_PHI,
  input  logic             RST_N,
  input  logic             BMREQ_N,
  input  logic             BRFSH_N,
  input  logic             BRD_N,
  input  logic             N_BWR,
  input  logic [NBANK-1:0] BANK_SEL,
  input  logic             DMA_N,
  input  logic             BUSAK_N,
  output logic             RAS_N,
  output logic             MUX,
  output logic [NBANK-1:0] CAS_N,
  output logic             WAIT_N,
  output logic             BUSRQ_N,
  output logic             ADDRBUFEN_N,
  output logic [RA_W-1:0]  RFSH_ROW,
  output logic             RFSH_ACT
);
  localparam int IRF_LEN = T_RAS_MUX + T_MUX_CAS + 1;

  // DMA_N and BUSAK_N come from other clock domains; everything else is B_PHI-synchronous.
  logic dma_s1_q, dma_s2_q, busak_s1_q, busak_s2_q;
  logic busrq_n_q, abe_n_q;

  always_ff @(posedge B_PHI or negedge RST_N) begin
    if (!RST_N) begin
      dma_s1_q   <= 1'b1;
      dma_s2_q   <= 1'b1;
      busak_s1_q <= 1'b1;
      busak_s2_q <= 1'b1;
      busrq_n_q  <= 1'b1;
      abe_n_q    <= 1'b0;
    end else begin
      dma_s1_q   <= DMA_N;
      dma_s2_q   <= dma_s1_q;
      busak_s1_q <= BUSAK_N;
      busak_s2_q <= busak_s1_q;
      busrq_n_q  <= dma_s2_q;
      // Z80 address buffers turn off only once the Z80 has actually released the bus.
      abe_n_q    <= ~busak_s2_q;
    end
  end

  logic            rf_en, rf_pending, rf_take, rf_done;
  logic [RA_W-1:0] rf_row;

  assign rf_en = ~busak_s2_q;

  mioc_rfsh_timer #(
    .RA_W     (RA_W),
    .RFSH_INT (RFSH_INT)
  ) u_rfsh_timer (
    .B_PHI   (B_PHI),
    .RST_N   (RST_N),
    .enable  (rf_en),
    .take    (rf_take),
    .done    (rf_done),
    .pending (rf_pending),
    .row     (rf_row)
  );

  state_e           state_q, state_d, idle_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d, wcnt_q, wcnt_d;
  logic [NBANK-1:0] bank_q, bank_d, cas_n_q, cas_n_d;
  logic             ras_n_q, ras_n_d, mux_q, mux_d, wait_n_q, wait_n_d, act_q, act_d;
  logic             acc_req, zrf_req, row_entry, blocked;

  assign acc_req = ~BMREQ_N & BRFSH_N & (~BRD_N | ~N_BWR);
  assign zrf_req = ~BMREQ_N & ~BRFSH_N;

  // Decision taken in IDLE and also on the last precharge cycle, so a request
  // waiting through PRE starts with exactly T_PRECHG cycles of RAS high.
  always_comb begin
    idle_nxt = ST_IDLE;
    if (rf_pending)   idle_nxt = ST_IRF;
    else if (zrf_req) idle_nxt = ST_ZRF;
    else if (acc_req) idle_nxt = ST_ROW;
  end

  always_comb begin
    state_d = state_q;
    rf_done = 1'b0;
    case (state_q)
      ST_IDLE: state_d = idle_nxt;
      ST_ROW:  if (cnt_q == CNT_W'(T_RAS_MUX - 1)) state_d = ST_COL;
      ST_COL:  if (cnt_q == CNT_W'(T_MUX_CAS - 1)) state_d = ST_HOLD;
      ST_HOLD: if (BMREQ_N) state_d = ST_PRE;
      ST_ZRF:  if (BMREQ_N) state_d = ST_PRE;
      ST_PRE:  if (cnt_q == CNT_W'(T_PRECHG - 1)) state_d = idle_nxt;
      ST_IRF: begin
        if (cnt_q == CNT_W'(IRF_LEN - 1)) begin
          state_d = ST_PRE;
          rf_done = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Phase counter restarts on every state change; it is only compared in timed states.
    cnt_d = (state_d == state_q) ? cnt_q + 1'b1 : '0;

    rf_take   = (state_d == ST_IRF) && (state_q != ST_IRF);
    row_entry = (state_d == ST_ROW) && (state_q != ST_ROW);
    bank_d    = row_entry ? BANK_SEL : bank_q;

    if (row_entry)        wcnt_d = CNT_W'(WAIT_CYC);
    else if (wcnt_q != 0) wcnt_d = wcnt_q - 1'b1;
    else                  wcnt_d = '0;

    blocked = acc_req && ((state_d == ST_IRF) || (state_d == ST_PRE));

    // Outputs are decoded from the next state and registered.
    ras_n_d  = !(state_d inside {ST_ROW, ST_COL, ST_HOLD, ST_ZRF, ST_IRF});
    mux_d    = (state_d == ST_COL) || (state_d == ST_HOLD);
    // A malformed bank select still runs RAS but fires no CAS.
    cas_n_d  = ((state_d == ST_HOLD) && is_onehot(8'(bank_d))) ? ~bank_d : '1;
    wait_n_d = !(blocked || (wcnt_d != 0));
    act_d    = (state_d == ST_IRF);
  end

  always_ff @(posedge B_PHI or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      wcnt_q   <= '0;
      bank_q   <= '0;
      ras_n_q  <= 1'b1;
      mux_q    <= 1'b0;
      cas_n_q  <= '1;
      wait_n_q <= 1'b1;
      act_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wcnt_q   <= wcnt_d;
      bank_q   <= bank_d;
      ras_n_q  <= ras_n_d;
      mux_q    <= mux_d;
      cas_n_q  <= cas_n_d;
      wait_n_q <= wait_n_d;
      act_q    <= act_d;
    end
  end

  assign RAS_N       = ras_n_q;
  assign MUX         = mux_q;
  assign CAS_N       = cas_n_q;
  assign WAIT_N      = wait_n_q;
  assign BUSRQ_N     = busrq_n_q;
  assign ADDRBUFEN_N = abe_n_q;
  assign RFSH_ROW    = rf_row;
  assign RFSH_ACT    = act_q;

endmodule

// File: tb/tb_mioc_dram_seq.sv
// Self-checking bench for mioc_dram_seq: a default instance plus one with
// WAIT_CYC=2 and RA_W=2 sharing the same stimulus (their state flow is identical).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_mioc_dram_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bmreq_n, brfsh_n, brd_n, bwr_n, dma_n, busak_n;
  logic [1:0] bank_sel;

  logic       ras_n0, mux0, wait_n0, busrq_n0, abe_n0, act0;
  logic [1:0] cas_n0;
  logic [6:0] row0;
  logic       ras_n1, mux1, wait_n1, busrq_n1, abe_n1, act1;
  logic [1:0] cas_n1;
  logic [1:0] row1;

  always #5 clk = ~clk;

  mioc_dram_seq u_dut0 (
    .B_PHI(clk), .RST_N(rst_n), .BMREQ_N(bmreq_n), .BRFSH_N(brfsh_n), .BRD_N(brd_n),
    .N_BWR(bwr_n), .BANK_SEL(bank_sel), .DMA_N(dma_n), .BUSAK_N(busak_n),
    .RAS_N(ras_n0), .MUX(mux0), .CAS_N(cas_n0), .WAIT_N(wait_n0), .BUSRQ_N(busrq_n0),
    .ADDRBUFEN_N(abe_n0), .RFSH_ROW(row0), .RFSH_ACT(act0)
  );

  mioc_dram_seq #(.WAIT_CYC(2), .RA_W(2)) u_dut1 (
    .B_PHI(clk), .RST_N(rst_n), .BMREQ_N(bmreq_n), .BRFSH_N(brfsh_n), .BRD_N(brd_n),
    .N_BWR(bwr_n), .BANK_SEL(bank_sel), .DMA_N(dma_n), .BUSAK_N(busak_n),
    .RAS_N(ras_n1), .MUX(mux1), .CAS_N(cas_n1), .WAIT_N(wait_n1), .BUSRQ_N(busrq_n1),
    .ADDRBUFEN_N(abe_n1), .RFSH_ROW(row1), .RFSH_ACT(act1)
  );

  // in  = {BMREQ_N, BRFSH_N, BRD_N, N_BWR, BANK_SEL[1:0]}
  // exp = {RAS_N, MUX, CAS_N[1:0], WAIT_N} of the default instance after the sampling edge
  typedef struct {
    logic [5:0] in;
    logic [4:0] exp;
  } vec_t;

  vec_t       vq[$];
  logic [6:0] blk_exp [8];
  int         checks = 0;
  int         failures = 0;
  int         rises, act_hi, run, first_rise;
  int         rise_row [8];
  logic       prev_act, seen_rq, seen_abe;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [5:0] i, input logic [4:0] e);
    vec_t v;
    v.in  = i;
    v.exp = e;
    vq.push_back(v);
  endtask

  task automatic set_idle();
    {bmreq_n, brfsh_n, brd_n, bwr_n, bank_sel} = 6'b1111_00;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_dut0"}, 32'({ras_n0, mux0, cas_n0, wait_n0, busrq_n0, abe_n0, act0}),
          32'(8'b1_0_11_1_1_0_0));
    check({tag, "_row0"}, 32'(row0), 32'(0));
    check({tag, "_dut1"}, 32'({ras_n1, mux1, cas_n1, wait_n1, busrq_n1, abe_n1, act1}),
          32'(8'b1_0_11_1_1_0_0));
    check({tag, "_row1"}, 32'(row1), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "tb_mioc_dram_seq timeout");
  end

  initial begin
    rst_n = 1'b0;
    set_idle();
    dma_n   = 1'b1;
    busak_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset("por");
    rst_n = 1'b1;
    tick();

    // ---------------- table: accesses, bad bank, Z80 refresh, request in PRE
    for (int k = 0; k < 4; k++)
      push(6'b0101_10, (k == 0) ? 5'b0_0_11_1 : (k == 1) ? 5'b0_1_11_1 : 5'b0_1_01_1);
    for (int k = 0; k < 3; k++) push(6'b1111_00, 5'b1_0_11_1);
    push(6'b0110_01, 5'b0_0_11_1);
    push(6'b0110_01, 5'b0_1_11_1);
    push(6'b0110_01, 5'b0_1_10_1);
    push(6'b1111_00, 5'b1_0_11_1);
    push(6'b1111_00, 5'b1_0_11_1);
    // back-to-back: taken on the last precharge cycle, RAS high exactly 2 cycles
    push(6'b0101_11, 5'b0_0_11_1);
    push(6'b0101_11, 5'b0_1_11_1);
    push(6'b0101_11, 5'b0_1_11_1);
    for (int k = 0; k < 3; k++) push(6'b1111_00, 5'b1_0_11_1);
    for (int k = 0; k < 3; k++) push(6'b0011_00, 5'b0_0_11_1);
    push(6'b1111_00, 5'b1_0_11_1);
    push(6'b0101_01, 5'b1_0_11_0);
    push(6'b0101_01, 5'b0_0_11_1);
    push(6'b0101_01, 5'b0_1_11_1);
    push(6'b0101_01, 5'b0_1_10_1);
    for (int k = 0; k < 3; k++) push(6'b1111_00, 5'b1_0_11_1);

    foreach (vq[k]) begin
      {bmreq_n, brfsh_n, brd_n, bwr_n, bank_sel} = vq[k].in;
      tick();
      check($sformatf("vec%0d", k), 32'({ras_n0, mux0, cas_n0, wait_n0}), 32'(vq[k].exp));
    end

    // ---------------- DMA handshake with 200 cycles of bus release
    dma_n = 1'b0;
    repeat (3) tick();
    check("busrq_assert", 32'(busrq_n0), 32'(0));
    busak_n    = 1'b0;
    rises      = 0;
    act_hi     = 0;
    run        = 0;
    prev_act   = 1'b0;
    first_rise = -1;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (k == 2) check("addrbuf_off", 32'(abe_n0), 32'(1));
      if (act0) begin
        act_hi++;
        run++;
        if (!prev_act) begin
          if (rises < 8) rise_row[rises] = 32'(row0);
          if (first_rise < 0) first_rise = k;
          rises++;
        end
      end else if (prev_act) begin
        check($sformatf("irf_width%0d", rises), run, 3);
        run = 0;
      end
      prev_act = act0;
    end
    check("irf_count", rises, 3);
    check("irf_first_edge", first_rise, 58);
    check("irf_act_cycles", act_hi, 9);
    for (int i = 0; i < 3; i++) check($sformatf("irf_row%0d", i), rise_row[i], i);
    check("rfsh_row_end", 32'(row0), 32'(3));
    if (first_rise < 0) first_rise = 58;
    busak_n = 1'b1;
    repeat (3) tick();
    check("addrbuf_on", 32'(abe_n0), 32'(0));
    dma_n = 1'b1;
    repeat (3) tick();
    check("busrq_release", 32'(busrq_n0), 32'(1));

    // ---------------- DMA request withdrawn before acknowledge
    seen_rq  = 1'b0;
    seen_abe = 1'b0;
    dma_n    = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) dma_n = 1'b1;
      tick();
      if (!busrq_n0) seen_rq = 1'b1;
      if (abe_n0) seen_abe = 1'b1;
    end
    check("abort_busrq_seen", 32'(seen_rq), 32'(1));
    check("abort_addrbuf_stays", 32'(seen_abe), 32'(0));
    check("abort_busrq_idle", 32'(busrq_n0), 32'(1));

    // ---------------- access arriving as refresh becomes pending
    // {RAS_N, RFSH_ACT, WAIT_N(dut0), WAIT_N(dut1), MUX, CAS_N[1:0]}
    blk_exp = '{7'b0100011, 7'b0100011, 7'b0100011, 7'b1000011,
                7'b1000011, 7'b0010011, 7'b0010111, 7'b0011101};
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    dma_n   = 1'b0;
    busak_n = 1'b0;
    repeat (first_rise) tick();
    {bmreq_n, brfsh_n, brd_n, bwr_n, bank_sel} = 6'b0101_10;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("blocked%0d", k),
            32'({ras_n0, act0, wait_n0, wait_n1, mux0, cas_n0}), 32'(blk_exp[k]));
    end
    set_idle();
    repeat (4) tick();
    busak_n = 1'b1;
    dma_n   = 1'b1;
    repeat (4) tick();

    // ---------------- refresh row wrap on the narrow-row instance
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    dma_n    = 1'b0;
    busak_n  = 1'b0;
    rises    = 0;
    prev_act = 1'b0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (act1 && !prev_act) begin
        if (rises < 8) rise_row[rises] = 32'(row1);
        rises++;
      end
      prev_act = act1;
    end
    check("wrap_irf_count", rises, 5);
    for (int i = 0; i < 5; i++) check($sformatf("wrap_row%0d", i), rise_row[i], i % 4);
    check("wrap_row1_end", 32'(row1), 32'(1));
    check("wrap_row0_end", 32'(row0), 32'(5));
    busak_n = 1'b1;
    dma_n   = 1'b1;
    repeat (4) tick();

    // ---------------- reset asserted in HOLD
    {bmreq_n, brfsh_n, brd_n, bwr_n, bank_sel} = 6'b0101_01;
    repeat (3) tick();
    check("hold_cas", 32'(cas_n0), 32'(2'b10));
    #2 rst_n = 1'b0;
    #1 check_reset("midhold");
    set_idle();
    tick();
    rst_n = 1'b1;
    tick();
    {bmreq_n, brfsh_n, brd_n, bwr_n, bank_sel} = 6'b0101_10;
    tick();
    check("postrst_ras", 32'({ras_n0, mux0, cas_n0}), 32'(4'b0_0_11));
    tick();
    check("postrst_mux", 32'({ras_n0, mux0, cas_n0}), 32'(4'b0_1_11));
    tick();
    check("postrst_cas", 32'({ras_n0, mux0, cas_n0}), 32'(4'b0_1_01));
    check("postrst_row", 32'(row0), 32'(0));
    set_idle();
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
